fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_pkg.sv | 14 +
 rtl/fwd_port_resolve.sv | 65 ++++++
 rtl/fwd_scoreboard.sv | 97 +++++++++
 tb/tb_fwd_scoreboard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// +----------------------------------------------------------------------+
// | fwd_scoreboard_pkg : shared encodings for the forwarding scoreboard  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package fwd_scoreboard_pkg;
  localparam int FWD_SEL_RF         = 0;
  localparam int FWD_SEL_STAGE_BASE = 1;
  localparam int TNEW_W             = 2;
  localparam int TUSE_W             = 2;
endpackage

`default_nettype wire

// File: rtl/fwd_port_resolve.sv
// +----------------------------------------------------------------------+
// | fwd_port_resolve : per-channel match, priority, stall and select     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fwd_port_resolve
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NSTAGE = 3,
  parameter int TW     = TNEW_W,
  parameter int SW     = $clog2(NSTAGE) + 1
) (
  input  logic [AW-1:0]                ra_i,
  input  logic [TW-1:0]                tuse_i,
  input  logic [DW-1:0]                rf_rdata_i,
  input  logic [NSTAGE-1:0]            ent_valid_i,
  input  logic [NSTAGE-1:0][AW-1:0]    ent_wa_i,
  input  logic [NSTAGE-1:0][TW-1:0]    ent_tnew_i,
  input  logic [NSTAGE-1:0][DW-1:0]    stage_wdata_i,
  output logic [DW-1:0]                fwd_data_o,
  output logic [SW-1:0]                fwd_sel_o,
  output logic                         stall_o
);

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [TW-1:0] hit_tnew;
  logic [DW-1:0] hit_data;

  // Ascending scan with a found flag: the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_tnew = '0;
    hit_data = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (!hit && (ra_i != '0) && ent_valid_i[k] && (ent_wa_i[k] == ra_i)) begin
        hit      = 1'b1;
        hit_idx  = SW'(k);
        hit_tnew = ent_tnew_i[k];
        hit_data = stage_wdata_i[k];
      end
    end
  end

  // The last tracked stage always retires this cycle, so it never holds D.
  assign stall_o = hit && (hit_idx != SW'(NSTAGE - 1)) && (hit_tnew > tuse_i);

  always_comb begin
    fwd_data_o = rf_rdata_i;
    fwd_sel_o  = SW'(FWD_SEL_RF);
    if (ra_i == '0) begin
      fwd_data_o = '0;
    end else if (hit && (hit_tnew == '0)) begin
      fwd_data_o = hit_data;
      fwd_sel_o  = SW'(FWD_SEL_STAGE_BASE) + hit_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// +----------------------------------------------------------------------+
// | fwd_scoreboard : Tnew/Tuse hazard scoreboard with operand forwarding |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NPORT  = 2,
  parameter int NSTAGE = 3,
  parameter int TW     = TNEW_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   d_wen,
  input  logic [AW-1:0]                          d_wa,
  input  logic [TW-1:0]                          d_tnew,
  input  logic [NPORT*AW-1:0]                    d_ra,
  input  logic [NPORT*TW-1:0]                    d_tuse,
  input  logic [NPORT*DW-1:0]                    rf_rdata,
  input  logic [NSTAGE*DW-1:0]                   stage_wdata,
  output logic [NPORT*DW-1:0]                    d_fwd_data,
  output logic [NPORT*($clog2(NSTAGE)+1)-1:0]    d_fwd_sel,
  output logic                                   stall,
  output logic [15:0]                            stall_cnt
);

  localparam int SW = $clog2(NSTAGE) + 1;

  logic [NSTAGE-1:0]         valid_q, valid_d;
  logic [NSTAGE-1:0][AW-1:0] wa_q, wa_d;
  logic [NSTAGE-1:0][TW-1:0] tnew_q, tnew_d;
  logic [15:0]               stall_cnt_q, stall_cnt_d;
  logic [NPORT-1:0]          port_stall;

  always_comb begin
    valid_d    = '0;
    wa_d       = '0;
    tnew_d     = '0;
    valid_d[0] = !stall && d_wen && (d_wa != '0);
    wa_d[0]    = d_wa;
    tnew_d[0]  = d_tnew;
    for (int k = 1; k < NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      wa_d[k]    = wa_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      wa_q        <= '0;
      tnew_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wa_q        <= wa_d;
      tnew_q      <= tnew_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  generate
    for (genvar p = 0; p < NPORT; p++) begin : g_port
      fwd_port_resolve #(
        .DW     (DW),
        .AW     (AW),
        .NSTAGE (NSTAGE),
        .TW     (TW),
        .SW     (SW)
      ) u_resolve (
        .ra_i          (d_ra[p*AW +: AW]),
        .tuse_i        (d_tuse[p*TW +: TW]),
        .rf_rdata_i    (rf_rdata[p*DW +: DW]),
        .ent_valid_i   (valid_q),
        .ent_wa_i      (wa_q),
        .ent_tnew_i    (tnew_q),
        .stage_wdata_i (stage_wdata),
        .fwd_data_o    (d_fwd_data[p*DW +: DW]),
        .fwd_sel_o     (d_fwd_sel[p*SW +: SW]),
        .stall_o       (port_stall[p])
      );
    end
  endgenerate

  assign stall     = |port_stall;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
// +----------------------------------------------------------------------+
// | tb_fwd_scoreboard : directed self-checking bench for fwd_scoreboard  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fwd_scoreboard;

  localparam logic [31:0] S0  = 32'hAAAA_0000;
  localparam logic [31:0] S1  = 32'hBBBB_1111;
  localparam logic [31:0] S2  = 32'hCCCC_2222;
  localparam logic [31:0] RF1 = 32'h2222_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_wen;
  logic [4:0]  d_wa;
  logic [1:0]  d_tnew;
  logic [9:0]  d_ra;
  logic [3:0]  d_tuse;
  logic [63:0] rf_rdata;
  logic [95:0] stage_wdata;
  logic [63:0] d_fwd_data;
  logic [5:0]  d_fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  logic        s_wen;
  logic [4:0]  s_wa;
  logic [4:0]  s_tnew;
  logic [4:0]  s_ra;
  logic [4:0]  s_tuse;
  logic [7:0]  s_fwd_data;
  logic [5:0]  s_fwd_sel;
  logic        s_stall;
  logic [15:0] s_stall_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_wen       (d_wen),
    .d_wa        (d_wa),
    .d_tnew      (d_tnew),
    .d_ra        (d_ra),
    .d_tuse      (d_tuse),
    .rf_rdata    (rf_rdata),
    .stage_wdata (stage_wdata),
    .d_fwd_data  (d_fwd_data),
    .d_fwd_sel   (d_fwd_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  // Deep pipeline instance so a single producer can hold stall for 31 cycles.
  fwd_scoreboard #(
    .DW (8), .AW (5), .NPORT (1), .NSTAGE (32), .TW (5)
  ) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_wen       (s_wen),
    .d_wa        (s_wa),
    .d_tnew      (s_tnew),
    .d_ra        (s_ra),
    .d_tuse      (s_tuse),
    .rf_rdata    (8'h5A),
    .stage_wdata ({32{8'h00}}),
    .d_fwd_data  (s_fwd_data),
    .d_fwd_sel   (s_fwd_sel),
    .stall       (s_stall),
    .stall_cnt   (s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    d_wen       = 1'b0;
    d_wa        = '0;
    d_tnew      = '0;
    d_ra        = '0;
    d_tuse      = '0;
    rf_rdata    = {RF1, 32'h1111_0000};
    stage_wdata = {S2, S1, S0};
    s_wen = 1'b0; s_wa = '0; s_tnew = '0; s_ra = '0; s_tuse = '0;

    #3;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_cnt",   {48'd0, stall_cnt}, 64'd0);
    chk("rst_sel",   {58'd0, d_fwd_sel}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // load-use: lw $8 tnew=2, consumer tuse=0
    d_wen = 1'b1; d_wa = 5'd8; d_tnew = 2'd2;
    #1 chk("lu_issue_stall", {63'd0, stall}, 64'd0);
    tick();
    d_wen = 1'b0; d_ra = {5'd0, 5'd8}; d_tuse = 4'd0;
    #1 chk("lu_stall1", {63'd0, stall}, 64'd1);
    chk("lu_cnt0", {48'd0, stall_cnt}, 64'd0);
    tick();
    chk("lu_stall2", {63'd0, stall}, 64'd1);
    chk("lu_cnt1", {48'd0, stall_cnt}, 64'd1);
    tick();
    chk("lu_release", {63'd0, stall}, 64'd0);
    chk("lu_sel0", {61'd0, d_fwd_sel[2:0]}, 64'd3);
    chk("lu_data0", {32'd0, d_fwd_data[31:0]}, {32'd0, S2});
    chk("lu_sel1_zero", {61'd0, d_fwd_sel[5:3]}, 64'd0);
    chk("lu_data1_zero", {32'd0, d_fwd_data[63:32]}, 64'd0);
    chk("lu_cnt2", {48'd0, stall_cnt}, 64'd2);

    // ALU back-to-back: addu $9 tnew=1, beq tuse=0
    d_ra = '0; d_wen = 1'b1; d_wa = 5'd9; d_tnew = 2'd1;
    tick();
    d_wen = 1'b0; d_ra = {5'd0, 5'd9}; d_tuse = 4'd0;
    #1 chk("alu_stall", {63'd0, stall}, 64'd1);
    tick();
    chk("alu_release", {63'd0, stall}, 64'd0);
    chk("alu_sel0", {61'd0, d_fwd_sel[2:0]}, 64'd2);
    chk("alu_data0", {32'd0, d_fwd_data[31:0]}, {32'd0, S1});
    chk("alu_cnt3", {48'd0, stall_cnt}, 64'd3);

    // per-channel tuse: ch1 tuse=1 covers tnew=1, ch0 tuse=0 does not
    d_ra = '0; d_wen = 1'b1; d_wa = 5'd9; d_tnew = 2'd1;
    tick();
    d_wen = 1'b0; d_ra = {5'd9, 5'd0}; d_tuse = {2'd1, 2'd0};
    #1 chk("tuse_nostall", {63'd0, stall}, 64'd0);
    chk("tuse_sel1_rf", {61'd0, d_fwd_sel[5:3]}, 64'd0);
    chk("tuse_data1_rf", {32'd0, d_fwd_data[63:32]}, {32'd0, RF1});
    d_ra = {5'd9, 5'd9};
    #1 chk("tuse_same_addr_stall", {63'd0, stall}, 64'd1);
    d_ra = '0;
    tick();
    chk("tuse_cnt3", {48'd0, stall_cnt}, 64'd3);

    // priority: $5 in E and M, both tnew=0
    d_wen = 1'b1; d_wa = 5'd5; d_tnew = 2'd0;
    tick(); tick();
    d_wen = 1'b0; d_ra = {5'd5, 5'd5}; d_tuse = 4'd0;
    #1 chk("prio_stall", {63'd0, stall}, 64'd0);
    chk("prio_sel0", {61'd0, d_fwd_sel[2:0]}, 64'd1);
    chk("prio_data0", {32'd0, d_fwd_data[31:0]}, {32'd0, S0});
    chk("prio_sel1", {61'd0, d_fwd_sel[5:3]}, 64'd1);

    // zero register: write to $0 in E, read $0 with junk rf data
    d_ra = '0; d_wen = 1'b1; d_wa = 5'd0; d_tnew = 2'd0;
    tick();
    d_wen = 1'b0; d_ra = {5'd5, 5'd0}; rf_rdata = {RF1, 32'hDEAD_BEEF};
    #1 chk("zero_data0", {32'd0, d_fwd_data[31:0]}, 64'd0);
    chk("zero_sel0", {61'd0, d_fwd_sel[2:0]}, 64'd0);
    chk("zero_stall", {63'd0, stall}, 64'd0);
    chk("zero_sel1_m", {61'd0, d_fwd_sel[5:3]}, 64'd2);
    chk("zero_data1_m", {32'd0, d_fwd_data[63:32]}, {32'd0, S1});

    // W entry with residual tnew never stalls and is not forwarded
    d_ra = '0; d_wen = 1'b1; d_wa = 5'd12; d_tnew = 2'd3;
    tick();
    d_wen = 1'b0;
    tick(); tick();
    d_ra = {5'd0, 5'd12}; d_tuse = 4'd0;
    #1 chk("w_nostall", {63'd0, stall}, 64'd0);
    chk("w_sel0_rf", {61'd0, d_fwd_sel[2:0]}, 64'd0);
    chk("w_data0_rf", {32'd0, d_fwd_data[31:0]}, 64'hDEAD_BEEF);

    // asynchronous reset in the middle of a stall
    d_ra = '0; d_wen = 1'b1; d_wa = 5'd7; d_tnew = 2'd3;
    tick();
    d_wen = 1'b0; d_ra = {5'd0, 5'd7}; d_tuse = {2'd0, 2'd1};
    #1 chk("ar_stall_before", {63'd0, stall}, 64'd1);
    chk("ar_cnt_before", {48'd0, stall_cnt}, 64'd3);
    #2 rst_n = 1'b0;
    #1 chk("ar_stall_low", {63'd0, stall}, 64'd0);
    chk("ar_cnt_low", {48'd0, stall_cnt}, 64'd0);
    chk("ar_sel_low", {58'd0, d_fwd_sel}, 64'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("ar_no_replay_stall", {63'd0, stall}, 64'd0);
    chk("ar_no_replay_data", {32'd0, d_fwd_data[31:0]}, 64'hDEAD_BEEF);
    tick();
    chk("ar_cnt_after", {48'd0, stall_cnt}, 64'd0);

    // saturation on the deep instance: 31 stalls per 32 cycles
    s_wen = 1'b1; s_wa = 5'd1; s_tnew = 5'd31; s_ra = 5'd1; s_tuse = 5'd0;
    #1 chk("sat_first_stall", {63'd0, s_stall}, 64'd0);
    repeat (32) tick();
    chk("sat_cnt_period", {48'd0, s_stall_cnt}, 64'd31);
    chk("sat_stall_gap", {63'd0, s_stall}, 64'd0);
    repeat (70000) tick();
    chk("sat_cnt_max", {48'd0, s_stall_cnt}, 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
